// File: rtl/chronos_pkg.sv
// Shared chronos configuration constants: register word map, reset defaults and
// the commit FSM state type used by tile_cfg_regs.
package chronos_pkg;

    localparam logic [7:0] ADDR_VERSION    = 8'h00;
    localparam logic [7:0] ADDR_CTRL       = 8'h01;
    localparam logic [7:0] ADDR_LOG_MASK   = 8'h02;
    localparam logic [7:0] ADDR_STATS_MASK = 8'h03;
    localparam logic [7:0] ADDR_GVT_PERIOD = 8'h04;
    localparam logic [7:0] ADDR_CQ_BASE    = 8'h10;

    localparam int CTRL_COMMIT_BIT = 0;
    localparam int CTRL_ERR_BIT    = 1;

    localparam logic       LOG_MASK_RESET_BIT   = 1'b0;
    localparam logic       STATS_MASK_RESET_BIT = 1'b1;
    localparam logic [3:0] GVT_PERIOD_RESET     = 4'd5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_APPLY
    } cfg_state_t;

endpackage

// File: rtl/tile_cfg_regs_if.sv
// Configuration bus: write channel with ready, read channel answered one cycle later.
interface cfg_if;
    logic        cfg_wvalid;
    logic        cfg_wready;
    logic [7:0]  cfg_waddr;
    logic [31:0] cfg_wdata;
    logic        cfg_arvalid;
    logic [7:0]  cfg_araddr;
    logic        cfg_rvalid;
    logic [31:0] cfg_rdata;

    modport master (
        output cfg_wvalid, cfg_waddr, cfg_wdata, cfg_arvalid, cfg_araddr,
        input  cfg_wready, cfg_rvalid, cfg_rdata
    );

    modport slave (
        input  cfg_wvalid, cfg_waddr, cfg_wdata, cfg_arvalid, cfg_araddr,
        output cfg_wready, cfg_rvalid, cfg_rdata
    );
endinterface

// File: rtl/cfg_quiesce_timer.sv
// Saturating drain timer: cleared and armed by start, disarmed by ack or when it
// reaches TIMEOUT-1, which it flags on timeout.
module cfg_quiesce_timer #(
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rstn,
    input  logic start,
    input  logic ack,
    output logic timeout
);
    localparam int              CW   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0]   LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          active_q, active_d;

    assign timeout = active_q && (cnt_q == LAST);

    // NOTE: every variable gets its default first so no path leaves it unassigned (no latch).
    always_comb begin
        cnt_d    = cnt_q;
        active_d = active_q;
        if (start) begin
            cnt_d    = '0;
            active_d = 1'b1;
        end else if (active_q) begin
            if (ack || timeout) active_d = 1'b0;
            else if (cnt_q != LAST) cnt_d = cnt_q + CW'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            active_q <= active_d;
        end
    end
endmodule

// File: rtl/tile_cfg_regs.sv
// Per-tile configuration registers with quiesce-and-commit update of live values.
// Define CFG_SHADOW_EN to stage writes in shadow registers applied on commit.
module tile_cfg_regs
    import chronos_pkg::*;
#(
    parameter int N_TILES           = 2,
    parameter int LOG_CQ_SLICE_SIZE = 7,
    parameter int CFG_VERSION       = 10,
    parameter int QUIESCE_TIMEOUT   = 1024
) (
    input  logic                                        clk,
    input  logic                                        rstn,
    cfg_if.slave                                        cfg,
    output logic                                        quiesce_req,
    input  logic                                        quiesce_ack,
    output logic [N_TILES-1:0]                          log_mask,
    output logic [N_TILES-1:0]                          stats_mask,
    output logic [3:0]                                  gvt_log_period,
    output logic [N_TILES*(LOG_CQ_SLICE_SIZE+1)-1:0]    cq_limit,
    output logic                                        cfg_updated
);
    localparam int             CQW    = LOG_CQ_SLICE_SIZE + 1;
    localparam logic [CQW-1:0] CQ_MAX = {1'b1, {LOG_CQ_SLICE_SIZE{1'b0}}};

    function automatic logic [CQW-1:0] clamp_cq(input logic [31:0] v);
        if (v == 32'd0) return CQW'(1);
        if (v > 32'(CQ_MAX)) return CQ_MAX;
        return v[CQW-1:0];
    endfunction

    cfg_state_t state_q, state_d;
    logic wready_q, rvalid_q, err_q, upd_q;
    logic [31:0] rdata_q, rd_data;
    logic tmr_start, tmr_timeout, commit, wr_fire, upd_d;

    logic [N_TILES-1:0] log_q, stats_q, rv_log, rv_stats, wr_log, wr_stats;
    logic [3:0]         gvt_q, rv_gvt, wr_gvt;
    logic [CQW-1:0]     cq_q [N_TILES];
    logic [CQW-1:0]     rv_cq [N_TILES];
    logic [CQW-1:0]     wr_cq [N_TILES];

    assign wr_fire = cfg.cfg_wvalid && wready_q;

`ifdef CFG_SHADOW_EN
    logic [N_TILES-1:0] sh_log_q, sh_stats_q;
    logic [3:0]         sh_gvt_q;
    logic [CQW-1:0]     sh_cq_q [N_TILES];

    assign rv_log   = sh_log_q;
    assign rv_stats = sh_stats_q;
    assign rv_gvt   = sh_gvt_q;
    assign rv_cq    = sh_cq_q;
    assign commit   = wr_fire && (cfg.cfg_waddr == ADDR_CTRL) && cfg.cfg_wdata[CTRL_COMMIT_BIT];
    assign upd_d    = (state_q == ST_APPLY);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sh_log_q   <= {N_TILES{LOG_MASK_RESET_BIT}};
            sh_stats_q <= {N_TILES{STATS_MASK_RESET_BIT}};
            sh_gvt_q   <= GVT_PERIOD_RESET;
            for (int t = 0; t < N_TILES; t++) sh_cq_q[t] <= CQ_MAX;
        end else begin
            sh_log_q   <= wr_log;
            sh_stats_q <= wr_stats;
            sh_gvt_q   <= wr_gvt;
            for (int t = 0; t < N_TILES; t++) sh_cq_q[t] <= wr_cq[t];
        end
    end
`else
    assign rv_log   = log_q;
    assign rv_stats = stats_q;
    assign rv_gvt   = gvt_q;
    assign rv_cq    = cq_q;
    assign commit   = 1'b0;
    assign upd_d    = wr_fire && ((cfg.cfg_waddr == ADDR_LOG_MASK) ||
                                  (cfg.cfg_waddr == ADDR_STATS_MASK) ||
                                  (cfg.cfg_waddr == ADDR_GVT_PERIOD) ||
                                  ((cfg.cfg_waddr >= ADDR_CQ_BASE) &&
                                   (cfg.cfg_waddr <  ADDR_CQ_BASE + 8'(N_TILES))));
`endif

    always_comb begin
        wr_log   = rv_log;
        wr_stats = rv_stats;
        wr_gvt   = rv_gvt;
        for (int t = 0; t < N_TILES; t++) wr_cq[t] = rv_cq[t];
        if (wr_fire) begin
            case (cfg.cfg_waddr)
                ADDR_LOG_MASK:   wr_log   = cfg.cfg_wdata[N_TILES-1:0];
                ADDR_STATS_MASK: wr_stats = cfg.cfg_wdata[N_TILES-1:0];
                ADDR_GVT_PERIOD: wr_gvt   = cfg.cfg_wdata[3:0];
                default: ;
            endcase
            for (int t = 0; t < N_TILES; t++)
                if (cfg.cfg_waddr == ADDR_CQ_BASE + 8'(t)) wr_cq[t] = clamp_cq(cfg.cfg_wdata);
        end
    end

    // Reads see register values before any same-cycle write lands.
    always_comb begin
        rd_data = '0;
        case (cfg.cfg_araddr)
            ADDR_VERSION:    rd_data = 32'(CFG_VERSION);
            ADDR_CTRL:       rd_data = {30'd0, err_q, (state_q != ST_IDLE)};
            ADDR_LOG_MASK:   rd_data = 32'(rv_log);
            ADDR_STATS_MASK: rd_data = 32'(rv_stats);
            ADDR_GVT_PERIOD: rd_data = 32'(rv_gvt);
            default: ;
        endcase
        for (int t = 0; t < N_TILES; t++)
            if (cfg.cfg_araddr == ADDR_CQ_BASE + 8'(t)) rd_data = 32'(rv_cq[t]);
    end

    always_comb begin
        state_d   = state_q;
        tmr_start = 1'b0;
        case (state_q)
            ST_IDLE: if (commit) begin
                state_d   = ST_DRAIN;
                tmr_start = 1'b1;
            end
            ST_DRAIN: begin
                if (quiesce_ack)      state_d = ST_APPLY;
                else if (tmr_timeout) state_d = ST_IDLE;
            end
            ST_APPLY: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    cfg_quiesce_timer #(.TIMEOUT(QUIESCE_TIMEOUT)) u_timer (
        .clk     (clk),
        .rstn    (rstn),
        .start   (tmr_start),
        .ack     (quiesce_ack && (state_q == ST_DRAIN)),
        .timeout (tmr_timeout)
    );

    // NOTE: memory-like arrays are reset here on purpose: every cq_limit has a defined power-up value.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= ST_IDLE;
            wready_q <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            upd_q    <= 1'b0;
            log_q    <= {N_TILES{LOG_MASK_RESET_BIT}};
            stats_q  <= {N_TILES{STATS_MASK_RESET_BIT}};
            gvt_q    <= GVT_PERIOD_RESET;
            for (int t = 0; t < N_TILES; t++) cq_q[t] <= CQ_MAX;
        end else begin
            state_q  <= state_d;
            wready_q <= (state_d == ST_IDLE);
            rvalid_q <= cfg.cfg_arvalid;
            if (cfg.cfg_arvalid) rdata_q <= rd_data;
            upd_q    <= upd_d;
            if ((state_q == ST_DRAIN) && tmr_timeout && !quiesce_ack)
                err_q <= 1'b1;
            else if (wr_fire && (cfg.cfg_waddr == ADDR_CTRL) && cfg.cfg_wdata[CTRL_ERR_BIT])
                err_q <= 1'b0;
`ifdef CFG_SHADOW_EN
            if (state_q == ST_APPLY) begin
                log_q   <= rv_log;
                stats_q <= rv_stats;
                gvt_q   <= rv_gvt;
                for (int t = 0; t < N_TILES; t++) cq_q[t] <= rv_cq[t];
            end
`else
            log_q   <= wr_log;
            stats_q <= wr_stats;
            gvt_q   <= wr_gvt;
            for (int t = 0; t < N_TILES; t++) cq_q[t] <= wr_cq[t];
`endif
        end
    end

    // Decoded from the state register so an asynchronous reset drops it at once.
    assign quiesce_req    = (state_q == ST_DRAIN);
    assign cfg.cfg_wready = wready_q;
    assign cfg.cfg_rvalid = rvalid_q;
    assign cfg.cfg_rdata  = rdata_q;
    assign log_mask       = log_q;
    assign stats_mask     = stats_q;
    assign gvt_log_period = gvt_q;
    assign cfg_updated    = upd_q;

    for (genvar t = 0; t < N_TILES; t++) begin : g_cq
        assign cq_limit[t*CQW +: CQW] = cq_q[t];
    end
endmodule

// File: doc/tile_cfg_regs.md
TILE_CFG_REGS -- requirements
Module: tile_cfg_regs

Interface
REQ-001 Parameter N_TILES, default 2: number of tiles served; 1..16.
REQ-002 Parameter LOG_CQ_SLICE_SIZE, default 7: log2 of per-tile CQ capacity.
REQ-003 Parameter CFG_VERSION, default 10: value returned by the VERSION register.
REQ-004 Parameter QUIESCE_TIMEOUT, default 1024: maximum cycles to wait for quiesce_ack; >=2.
REQ-005 clk  in  1  single clock.
REQ-006 rstn  in  1  asynchronous active-low reset.
REQ-007 cfg_wvalid / cfg_wready  in / out  1 / 1  write handshake.
REQ-008 cfg_waddr / cfg_wdata  in  8 / 32  write word address and data.
REQ-009 cfg_arvalid / cfg_araddr  in  1 / 8  read request; always accepted.
REQ-010 cfg_rvalid / cfg_rdata  out  1 / 32  read response.
REQ-011 quiesce_req / quiesce_ack  out / in  1 / 1  drain handshake with the tiles.
REQ-012 log_mask / stats_mask  out  N_TILES each  live per-tile logging and stats enables.
REQ-013 gvt_log_period  out  4  live log2 GVT period.
REQ-014 cq_limit  out  N_TILES x (LOG_CQ_SLICE_SIZE+1)  live per-tile CQ occupancy limit.
REQ-015 cfg_updated  out  1  one-cycle pulse when the live values change.

Function
REQ-016 Word map: 0x00 VERSION (read-only); 0x01 CTRL; 0x02 LOG_MASK; 0x03 STATS_MASK; 0x04 GVT_LOG_PERIOD[3:0]; 0x10+t CQ_LIMIT of tile t, for t < N_TILES.
REQ-017 Unmapped addresses SHALL read 0, and writes to them SHALL be ignored and still acknowledged.
REQ-018 A write completes in the cycle where cfg_wvalid && cfg_wready.
REQ-019 cfg_wready SHALL be 1 only in state IDLE.
REQ-020 A read SHALL return data one cycle after cfg_arvalid; cfg_rvalid is high for exactly that cycle.
REQ-021 A write to CQ_LIMIT SHALL clamp the value to the range 1..2^LOG_CQ_SLICE_SIZE.
REQ-022 Writable fields SHALL be truncated to their field width.
REQ-023 CTRL read: bit0 = busy (state is not IDLE); bit1 = sticky timeout error.
REQ-024 CTRL write: bit0=1 requests a commit; bit1=1 clears the error bit.
REQ-025 FSM states are IDLE, DRAIN and APPLY.
REQ-026 IDLE -> DRAIN on a commit write; quiesce_req rises the next cycle.
REQ-027 In DRAIN, a saturating cycle counter counts from 0.
REQ-028 DRAIN -> APPLY when quiesce_ack=1.
REQ-029 DRAIN -> IDLE when the counter reaches QUIESCE_TIMEOUT-1 without ack; the error bit sets and shadow values are retained.
REQ-030 If quiesce_ack and the timeout coincide, the ack SHALL win.
REQ-031 APPLY lasts one cycle: it copies shadow to live, pulses cfg_updated, deasserts quiesce_req, then returns to IDLE.
REQ-032 A commit with shadow equal to live SHALL still run the full handshake and pulse cfg_updated.
REQ-033 A read and a write in the same cycle to the same address SHALL return the pre-write value.

Reset
REQ-034 On rstn low, asynchronously: state IDLE; cfg_wready 0 until the first cycle after release.
REQ-035 On reset: cfg_rvalid, cfg_rdata, quiesce_req, cfg_updated and error are all 0.
REQ-036 On reset, live and shadow take: log_mask 0, stats_mask all 1s, gvt_log_period 5, every cq_limit 2^LOG_CQ_SLICE_SIZE.
REQ-037 Reset during DRAIN SHALL drop quiesce_req immediately and discard any pending commit.

Configuration
REQ-038 With CFG_SHADOW_EN defined: writes go to shadow registers, reads return shadow values, and live outputs change only in APPLY.
REQ-039 Without CFG_SHADOW_EN: writes update the live values directly and pulse cfg_updated the next cycle.
REQ-040 Without CFG_SHADOW_EN: the commit bit is ignored, the FSM stays in IDLE, and quiesce_req stays 0.

Structure
REQ-041 The register address constants, reset defaults and the cfg_state_t enum SHALL live in the shared chronos package.
REQ-042 The DRAIN timeout counter SHALL be a sub-module, cfg_quiesce_timer (start, ack, timeout outputs).

Verification
REQ-043 Read 0x00 after reset -> cfg_rdata = 10 one cycle later; read 0x10 -> 128 (LOG_CQ_SLICE_SIZE=7).
REQ-044 (SHADOW_EN) Write 0x02=0x3, then write 0x01=0x1, then ack 5 cycles after quiesce_req -> log_mask stays 0 until APPLY, becomes 0x3 with cfg_updated for 1 cycle, and quiesce_req falls.
REQ-045 Write 0x11=0 -> read 0x11 returns 1; write 0x11=500 -> read returns 128.
REQ-046 Commit with no ack and QUIESCE_TIMEOUT=16 -> IDLE after 16 DRAIN cycles, CTRL reads 0x2, live unchanged; writing CTRL=0x2 -> CTRL reads 0.
REQ-047 While in DRAIN, assert cfg_wvalid -> cfg_wready=0 until back in IDLE; pulse rstn low during DRAIN -> quiesce_req=0 immediately and all outputs at reset values.
REQ-048 Without CFG_SHADOW_EN: write 0x04=7 -> gvt_log_period=7 and cfg_updated pulses the next cycle; write 0x01=1 -> quiesce_req remains 0.
